// File: rtl/gate_truth_table_reader_if.sv
// Request/result and gate-under-test signals for gate_truth_table_reader.
// master: the requester that also closes the GUT loop; slave: the reader itself.
interface gate_truth_table_reader_if;
    logic       start;
    logic       gut_a;
    logic       gut_b;
    logic       gut_z;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic [2:0] gate_code;
    logic       err;

    modport master (
        output start,
        output gut_z,
        input  gut_a,
        input  gut_b,
        input  busy,
        input  done,
        input  truth_table,
        input  gate_code,
        input  err
    );

    modport slave (
        input  start,
        input  gut_z,
        output gut_a,
        output gut_b,
        output busy,
        output done,
        output truth_table,
        output gate_code,
        output err
    );
endinterface

// File: rtl/gate_truth_table_reader.sv
// Drives the four input vectors of a 2-input gate, captures its truth table and decodes the gate type.
// Optional GATE_READER_DOUBLE_SAMPLE_EN: two samples per vector, mismatch sets err and forces gate_code to 0.
module gate_truth_table_reader #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    gate_truth_table_reader_if.slave   bus
);

    localparam int unsigned CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DECODE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_idx;
    logic [1:0]      w_idx_nxt;
    logic [1:0]      w_idx_inc;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic            r_gut_a;
    logic            w_gut_a_nxt;
    logic            r_gut_b;
    logic            w_gut_b_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic [3:0]      r_tt;
    logic [3:0]      w_tt_nxt;
    logic [2:0]      r_code;
    logic [2:0]      w_code_nxt;
    logic [2:0]      w_decoded;
    logic            w_capture;

`ifdef GATE_READER_DOUBLE_SAMPLE_EN
    logic            r_phase;
    logic            w_phase_nxt;
    logic            r_s0;
    logic            w_s0_nxt;
    logic            r_err;
    logic            w_err_nxt;

    // Second SAMPLE cycle is the one that commits into the truth table.
    assign w_capture = r_phase;
`else
    assign w_capture = 1'b1;
`endif

    assign w_idx_inc = r_idx + 2'd1;
    assign w_cnt_inc = r_cnt + CW'(1);

    always_comb begin
        w_decoded = 3'd0;
        case (r_tt)
            4'b1000: w_decoded = 3'd1;
            4'b0111: w_decoded = 3'd2;
            4'b1110: w_decoded = 3'd3;
            4'b0001: w_decoded = 3'd4;
            4'b0110: w_decoded = 3'd5;
            4'b1001: w_decoded = 3'd6;
            4'b0000,
            4'b1111: w_decoded = 3'd7;
            default: w_decoded = 3'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_gut_a_nxt = r_gut_a;
        w_gut_b_nxt = r_gut_b;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_tt_nxt    = r_tt;
        w_code_nxt  = r_code;
`ifdef GATE_READER_DOUBLE_SAMPLE_EN
        w_phase_nxt = r_phase;
        w_s0_nxt    = r_s0;
        w_err_nxt   = r_err;
`endif

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_APPLY;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                    w_gut_a_nxt = 1'b0;
                    w_gut_b_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_tt_nxt    = '0;
                    w_code_nxt  = '0;
`ifdef GATE_READER_DOUBLE_SAMPLE_EN
                    w_phase_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
`endif
                end
            end

            S_APPLY: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == CW'(SETTLE_CYCLES)) begin
                    w_state_nxt = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
`ifdef GATE_READER_DOUBLE_SAMPLE_EN
                w_phase_nxt = ~r_phase;
                if (!r_phase) begin
                    w_s0_nxt = bus.gut_z;
                end else if (r_s0 != bus.gut_z) begin
                    w_err_nxt = 1'b1;
                end
`endif
                if (w_capture) begin
                    w_tt_nxt[r_idx] = bus.gut_z;
                    if (r_idx != 2'd3) begin
                        w_idx_nxt   = w_idx_inc;
                        w_gut_a_nxt = w_idx_inc[1];
                        w_gut_b_nxt = w_idx_inc[0];
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_APPLY;
                    end else begin
                        w_state_nxt = S_DECODE;
                    end
                end
            end

            S_DECODE: begin
`ifdef GATE_READER_DOUBLE_SAMPLE_EN
                w_code_nxt  = r_err ? 3'd0 : w_decoded;
`else
                w_code_nxt  = w_decoded;
`endif
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_gut_a_nxt = 1'b0;
                w_gut_b_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_gut_a <= 1'b0;
            r_gut_b <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tt    <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gut_a <= w_gut_a_nxt;
            r_gut_b <= w_gut_b_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_tt    <= w_tt_nxt;
            r_code  <= w_code_nxt;
        end
    end

`ifdef GATE_READER_DOUBLE_SAMPLE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_s0    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_s0    <= w_s0_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gut_a       = r_gut_a;
    assign bus.gut_b       = r_gut_b;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.truth_table = r_tt;
    assign bus.gate_code   = r_code;

endmodule

// File: tb/tb_gate_truth_table_reader.sv
// Directed bench for gate_truth_table_reader: a behavioural GUT selected by mode closes the loop.
module tb_gate_truth_table_reader;

    localparam int S = 2;
`ifdef GATE_READER_DOUBLE_SAMPLE_EN
    localparam int PER = S + 2;
`else
    localparam int PER = S + 1;
`endif
    localparam int N = 4 * PER;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;
    logic z_ovr = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    gate_truth_table_reader_if bus ();

    gate_truth_table_reader #(.SETTLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural gate under test
    always_comb begin
        bus.gut_z = 1'b0;
        case (mode)
            0: bus.gut_z = bus.gut_a & bus.gut_b;
            1: bus.gut_z = ~(bus.gut_a & bus.gut_b);
            2: bus.gut_z = bus.gut_a | bus.gut_b;
            3: bus.gut_z = ~(bus.gut_a | bus.gut_b);
            4: bus.gut_z = bus.gut_a ^ bus.gut_b;
            5: bus.gut_z = ~(bus.gut_a ^ bus.gut_b);
            6: bus.gut_z = 1'b1;
            7: bus.gut_z = bus.gut_a;
            8: bus.gut_z = z_ovr;
            default: bus.gut_z = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input string tag, input int mode_i, input logic [3:0] exp_tt,
                       input logic [2:0] exp_code, input bit hold);
        int v;
        mode = mode_i;
        bus.start = 1'b1;
        tick();
        if (!hold) bus.start = 1'b0;
        chk({tag, "_accept_busy"}, 8'(bus.busy), 8'd1);
        chk({tag, "_accept_tt"}, 8'(bus.truth_table), 8'd0);
        chk({tag, "_accept_err"}, 8'(bus.err), 8'd0);
        for (int j = 1; j <= N + 1; j++) begin
            tick();
            v = j / PER;
            if (v > 3) v = 3;
            if (j == N + 1) v = 0;
            chk({tag, "_vec"}, 8'({bus.gut_a, bus.gut_b}), 8'(v));
            chk({tag, "_done"}, 8'(bus.done), 8'(j == N + 1));
            chk({tag, "_busy"}, 8'(bus.busy), 8'(j <= N));
        end
        bus.start = 1'b0;
        chk({tag, "_tt"}, 8'(bus.truth_table), 8'(exp_tt));
        chk({tag, "_code"}, 8'(bus.gate_code), 8'(exp_code));
        chk({tag, "_err"}, 8'(bus.err), 8'd0);
        tick();
        chk({tag, "_done_fall"}, 8'(bus.done), 8'd0);
        chk({tag, "_idle_busy"}, 8'(bus.busy), 8'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 8'(bus.busy), 8'd0);
        chk("rst_done", 8'(bus.done), 8'd0);
        chk("rst_tt", 8'(bus.truth_table), 8'd0);
        chk("rst_code", 8'(bus.gate_code), 8'd0);
        chk("rst_err", 8'(bus.err), 8'd0);
        chk("rst_vec", 8'({bus.gut_a, bus.gut_b}), 8'd0);

        run("and",   0, 4'b1000, 3'd1, 1'b0);
        run("nand",  1, 4'b0111, 3'd2, 1'b0);
        run("or",    2, 4'b1110, 3'd3, 1'b0);
        run("nor",   3, 4'b0001, 3'd4, 1'b0);
        run("xor",   4, 4'b0110, 3'd5, 1'b0);
        run("xnor",  5, 4'b1001, 3'd6, 1'b0);
        run("const", 6, 4'b1111, 3'd7, 1'b0);
        run("z_eq_a", 7, 4'b1100, 3'd0, 1'b0);

        mode = 0;
        repeat (5) tick();
        chk("hold_tt", 8'(bus.truth_table), 8'b1100);
        chk("hold_code", 8'(bus.gate_code), 8'd0);

        // Reset during the third APPLY, then a clean run
        mode = 4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2 * PER + 1) tick();
        chk("mid_busy_pre", 8'(bus.busy), 8'd1);
        chk("mid_vec_pre", 8'({bus.gut_a, bus.gut_b}), 8'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 8'(bus.busy), 8'd0);
        chk("mid_rst_done", 8'(bus.done), 8'd0);
        chk("mid_rst_tt", 8'(bus.truth_table), 8'd0);
        chk("mid_rst_code", 8'(bus.gate_code), 8'd0);
        chk("mid_rst_vec", 8'({bus.gut_a, bus.gut_b}), 8'd0);
        tick();
        chk("mid_rst_stay_idle", 8'(bus.busy), 8'd0);
        run("after_rst", 4, 4'b0110, 3'd5, 1'b0);

        run("start_busy", 3, 4'b0001, 3'd4, 1'b1);

        // Start held continuously: second accept lands on the done cycle
        mode = 0;
        bus.start = 1'b1;
        tick();
        for (int j = 1; j <= 2 * N + 3; j++) begin
            tick();
            chk("b2b_done", 8'(bus.done), 8'((j == N + 1) || (j == 2 * N + 3)));
            if (j == N + 1 || j == 2 * N + 3) begin
                chk("b2b_tt", 8'(bus.truth_table), 8'b1000);
                chk("b2b_code", 8'(bus.gate_code), 8'd1);
            end
            if (j == N + 2) begin
                chk("b2b_reaccept_busy", 8'(bus.busy), 8'd1);
                chk("b2b_clear_tt", 8'(bus.truth_table), 8'd0);
                chk("b2b_clear_code", 8'(bus.gate_code), 8'd0);
            end
        end
        bus.start = 1'b0;
        tick();
        chk("b2b_end_busy", 8'(bus.busy), 8'd0);

`ifdef GATE_READER_DOUBLE_SAMPLE_EN
        // gut_z changes between the two samples of vector 10
        mode = 8;
        z_ovr = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 1; j <= N + 1; j++) begin
            tick();
            if (j == 2 * PER + S + 1) z_ovr = 1'b1;
            if (j == 2 * PER + S + 2) z_ovr = 1'b0;
            chk("ds_done", 8'(bus.done), 8'(j == N + 1));
        end
        chk("ds_err", 8'(bus.err), 8'd1);
        chk("ds_code", 8'(bus.gate_code), 8'd0);
        chk("ds_tt", 8'(bus.truth_table), 8'b0100);
        tick();
        chk("ds_err_sticky", 8'(bus.err), 8'd1);
        run("ds_xor", 4, 4'b0110, 3'd5, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
